sm2_kdf_ctrl: RTL and testbench
===============================

// Module: sm2_kdf_ctrl
// PURPOSE
//  Sequences the KDF core for the SM2 encryption/decryption flow.
//  - Builds Z = x2||y2, range-checks klen, launches one KDF run and waits for kout_valid (with timeout).
//  - Truncates kout to klen bits and performs the SM2 "t == 0" check.
//  - Reports result + status to the SM2 top FSM, which picks a new k on a zero t.
// PARAMETERS
//  KMAX        1024  max klen in bits (= kout width)
//  TIMEOUT     4096  cycles allowed from kdf_start to kdf_kout_valid
//  TCW         13    timeout counter width (>= clog2(TIMEOUT)+1)
// PORTS
//  clk             in   1     system clock, rising edge
//  rstn            in   1     async active-low reset
//  req             in   1     start request, sampled only in IDLE
//  req_x2          in   256   x2 coordinate
//  req_y2          in   256   y2 coordinate
//  req_klen        in   32    requested key length, bits
//  abort           in   1     cancel the current operation
//  busy            out  1     high in every state except IDLE
//  kdf_zin         out  512   {x2,y2}, held stable START..WAIT
//  kdf_start       out  1     one-cycle launch pulse to KDF
//  kdf_klen        out  32    latched klen, held stable START..WAIT
//  kdf_kout        in   1024  KDF output, MSB-aligned
//  kdf_kout_valid  in   1     one-cycle KDF result strobe
//  t_out           out  1024  masked key t, held until next accepted req
//  done            out  1     one-cycle completion pulse
//  status          out  2     0=OK 1=ZERO_T 2=BAD_KLEN 3=TIMEOUT; valid with done, held after
// BEHAVIOUR
//  - Reset: state=IDLE; busy, kdf_start, done = 0; kdf_zin, kdf_klen, t_out, status, counter = 0.
//  - IDLE: req=1 latches x2, y2, klen -> CHECK. req while busy is ignored; no queueing.
//  - CHECK (1 cycle):
//    - klen==0 or klen>KMAX -> DONE with status=2; no kdf_start.
//    - otherwise -> START.
//  - START (1 cycle): kdf_start=1, counter cleared -> WAIT.
//  - WAIT: counter increments each cycle.
//    - kdf_kout_valid=1 -> register t = kdf_kout & mask(klen) -> ZCHK.
//    - counter==TIMEOUT-1 without valid -> FLUSH with pending status=3.
//  - mask(klen): bits [1023 -: klen] kept; bits [1023-klen:0] forced to 0. klen=1024 keeps all bits.
//  - ZCHK (1 cycle): t==0 -> status=1, else status=0 -> DONE.
//  - DONE (1 cycle): done=1, t_out/status updated this cycle -> IDLE.
//  - Latency:
//    - req at edge N -> kdf_start high in cycle N+2.
//    - kdf_kout_valid at cycle M -> done high in cycle M+2.
//    - Bad klen: done in cycle N+2.
//  - FLUSH: KDF may still be running.
//    - Stay in FLUSH until kdf_kout_valid or a further TIMEOUT cycles.
//    - Then -> DONE(status 3) after a timeout, or -> IDLE with no done after an abort.
//  - abort in CHECK or START -> IDLE next cycle, no done, no kdf_start.
//  - abort in WAIT -> FLUSH. abort in ZCHK or DONE is ignored (operation completes).
//  - abort has priority over kdf_kout_valid in the same WAIT cycle.
//  - kdf_kout_valid outside WAIT/FLUSH is ignored.
//  - Reset asserted mid-operation returns everything to the reset values immediately.
// TESTING
//  1. x2||y2 = 512'h64D2...BF78, klen=1000; KDF model returns after 70 cycles
//     -> one kdf_start, done 2 cycles after valid, status=0, t_out[23:0]=0.
//  2. klen=0, then klen=1025 -> done at N+2, status=2, kdf_start never asserted.
//  3. KDF model returns kout with only bit 0 set, klen=1000 -> masked t=0, status=1.
//  4. KDF model never responds -> done TIMEOUT+1..2*TIMEOUT+3 cycles after start, status=3;
//     busy high throughout.
//  5. abort 10 cycles into WAIT; valid arrives 20 cycles later
//     -> no done, busy drops the cycle after valid; second req then runs normally.
//  6. req pulsed while busy, plus rstn dropped mid-WAIT
//     -> extra req ignored; all outputs at reset values while rstn=0.

Source files
------------

// File: rtl/sm2_kdf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sm2_kdf_ctrl                                                               |
// | Sequences one KDF run for SM2: Z = x2||y2, klen checks, t masking, t==0.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sm2_kdf_ctrl #(
  parameter int KMAX    = 1024,
  parameter int TIMEOUT = 4096,
  parameter int TCW     = 13
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req,
  input  logic [255:0]    req_x2,
  input  logic [255:0]    req_y2,
  input  logic [31:0]     req_klen,
  input  logic            abort,
  output logic            busy,
  output logic [511:0]    kdf_zin,
  output logic            kdf_start,
  output logic [31:0]     kdf_klen,
  input  logic [KMAX-1:0] kdf_kout,
  input  logic            kdf_kout_valid,
  output logic [KMAX-1:0] t_out,
  output logic            done,
  output logic [1:0]      status
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ZCHK  = 3'd4,
    S_DONE  = 3'd5,
    S_FLUSH = 3'd6
  } state_t;

  localparam logic [1:0]     c_st_ok   = 2'd0;
  localparam logic [1:0]     c_st_zero = 2'd1;
  localparam logic [1:0]     c_st_bad  = 2'd2;
  localparam logic [1:0]     c_st_tmo  = 2'd3;
  localparam logic [31:0]    c_kmax    = 32'(KMAX);
  localparam logic [TCW-1:0] c_tmo_last = TCW'(TIMEOUT - 1);

  state_t          r_state;
  logic [TCW-1:0]  r_cnt;
  logic [KMAX-1:0] r_t;
  logic [KMAX-1:0] r_t_out;
  logic [511:0]    r_zin;
  logic [31:0]     r_klen;
  logic [1:0]      r_pend;
  logic [1:0]      r_status;
  logic            r_abort;
  logic            r_busy;
  logic            r_start;
  logic            r_done;
  logic [KMAX-1:0] w_mask;

  // Keep the top klen bits of the MSB-aligned KDF output; klen>=KMAX keeps all.
  assign w_mask = ~({KMAX{1'b1}} >> r_klen);

  assign busy      = r_busy;
  assign kdf_zin   = r_zin;
  assign kdf_start = r_start;
  assign kdf_klen  = r_klen;
  assign t_out     = r_t_out;
  assign done      = r_done;
  assign status    = r_status;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_t      <= '0;
      r_t_out  <= '0;
      r_zin    <= '0;
      r_klen   <= '0;
      r_pend   <= c_st_ok;
      r_status <= c_st_ok;
      r_abort  <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_zin   <= {req_x2, req_y2};
            r_klen  <= req_klen;
            r_t     <= '0;
            r_pend  <= c_st_ok;
            r_abort <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_klen == 32'd0 || r_klen > c_kmax) begin
            r_pend  <= c_st_bad;
            r_state <= S_DONE;
          end else begin
            r_state <= S_START;
          end
        end
        S_START: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_abort <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_FLUSH;
          end else if (kdf_kout_valid) begin
            r_t     <= kdf_kout & w_mask;
            r_state <= S_ZCHK;
          end else if (r_cnt == c_tmo_last) begin
            r_pend  <= c_st_tmo;
            r_cnt   <= '0;
            r_state <= S_FLUSH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ZCHK: begin
          r_pend  <= (r_t == '0) ? c_st_zero : c_st_ok;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_t_out  <= r_t;
          r_status <= r_pend;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_FLUSH: begin
          // Drain a possibly still-running KDF so its late strobe cannot leak into the next run.
          if (abort) begin
            r_abort <= 1'b1;
          end
          if (kdf_kout_valid || r_cnt == c_tmo_last) begin
            if (r_abort || abort) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm2_kdf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sm2_kdf_ctrl                                                            |
// | Directed vector bench for sm2_kdf_ctrl with a behavioural KDF responder.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sm2_kdf_ctrl;

  localparam int KMAX    = 1024;
  localparam int TIMEOUT = 4096;
  localparam int TCW     = 13;
  localparam logic [255:0] X2 =
    256'h64D20D27_D0632957_F8028C1E_024F6B02_EDF23102_A566C932_AE8BD613_A8E865FE;
  localparam logic [255:0] Y2 =
    256'h58D225EC_A784AE30_0A81A2D4_8281A828_E1CEDF11_C4219099_84026537_5077BF78;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            req = 1'b0;
  logic [255:0]    req_x2 = '0;
  logic [255:0]    req_y2 = '0;
  logic [31:0]     req_klen = '0;
  logic            abort = 1'b0;
  logic            busy;
  logic [511:0]    kdf_zin;
  logic            kdf_start;
  logic [31:0]     kdf_klen;
  logic [KMAX-1:0] kdf_kout = '0;
  logic            kdf_kout_valid = 1'b0;
  logic [KMAX-1:0] t_out;
  logic            done;
  logic [1:0]      status;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  sm2_kdf_ctrl #(.KMAX(KMAX), .TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_x2(req_x2), .req_y2(req_y2),
    .req_klen(req_klen), .abort(abort), .busy(busy), .kdf_zin(kdf_zin),
    .kdf_start(kdf_start), .kdf_klen(kdf_klen), .kdf_kout(kdf_kout),
    .kdf_kout_valid(kdf_kout_valid), .t_out(t_out), .done(done), .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] klen;
    int          sel;        // kout pattern
    int          delay;      // cycles from kdf_start to valid, -1 = never
    int          req_pulse;  // cycles after kdf_start for a stray req, -1 = none
    logic [1:0]  exp_status;
    int          exp_nstart;
  } vec_t;

  vec_t tab[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [KMAX-1:0] act, input logic [KMAX-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got[hi64]=%h got[lo64]=%h expected[hi64]=%h expected[lo64]=%h",
               name, act[KMAX-1 -: 64], act[63:0], exp[KMAX-1 -: 64], exp[63:0]);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":busy"}, 64'(busy), 64'd0);
    chk({tag, ":kdf_start"}, 64'(kdf_start), 64'd0);
    chk({tag, ":done"}, 64'(done), 64'd0);
    chk({tag, ":status"}, 64'(status), 64'd0);
    chk({tag, ":kdf_klen"}, 64'(kdf_klen), 64'd0);
    chk({tag, ":kdf_zin_zero"}, 64'(kdf_zin == '0), 64'd1);
    chk_wide({tag, ":t_out"}, t_out, '0);
  endtask

  function automatic logic [KMAX-1:0] gen_kout(input int sel, input logic [31:0] klen);
    logic [KMAX-1:0] r;
    r = '0;
    case (sel)
      0: r = '1;
      1: r[0] = 1'b1;
      2: r = {16{64'hA5C3_1E96_5A3C_F1D7}};
      3: r[KMAX - int'(klen)] = 1'b1;
      default: r[KMAX - int'(klen) - 1] = 1'b1;
    endcase
    return r;
  endfunction

  // Bit i survives when it lies within the top klen bits.
  function automatic logic [KMAX-1:0] model_t(input logic [KMAX-1:0] k, input logic [31:0] klen);
    logic [KMAX-1:0] r;
    r = '0;
    for (int i = 0; i < KMAX; i++)
      if (KMAX - i <= int'(klen)) r[i] = k[i];
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    int n, s, m, d, nstart, lat;
    bit gap, q;
    logic [KMAX-1:0] kout, exp_t;
    s = -1; m = -1; d = -1; nstart = 0; gap = 0; q = 0;
    kout  = gen_kout(v.sel, v.klen);
    exp_t = (v.exp_status <= 2'd1) ? model_t(kout, v.klen) : '0;
    @(negedge clk);
    req = 1'b1; req_x2 = X2; req_y2 = Y2; req_klen = v.klen;
    n = cyc + 1;
    for (int i = 0; i < 3 * TIMEOUT && d < 0; i++) begin
      @(negedge clk);
      req = 1'b0;
      kdf_kout_valid = 1'b0;
      if (kdf_start) begin nstart++; s = cyc; end
      if (done) d = cyc;
      else begin
        if (!busy) gap = 1;
        if (s >= 0 && v.delay >= 0 && m < 0 && cyc == s + v.delay) begin
          kdf_kout_valid = 1'b1; kdf_kout = kout; m = cyc + 1;
        end
        if (s >= 0 && cyc == s + v.req_pulse) begin
          req = 1'b1; req_klen = 32'd0;
        end
      end
    end
    kdf_kout_valid = 1'b0;
    req = 1'b0;
    chk({v.name, ":done_seen"}, 64'(d >= 0), 64'd1);
    chk({v.name, ":kdf_start_count"}, 64'(nstart), 64'(v.exp_nstart));
    if (v.exp_nstart == 1 && s >= 0) chk({v.name, ":start_latency"}, 64'(s - n), 64'd2);
    lat = d - s;
    case (v.exp_status)
      2'd0, 2'd1: chk({v.name, ":done_after_valid"}, 64'(d - m), 64'd2);
      2'd2:       chk({v.name, ":done_after_req"}, 64'(d - n), 64'd2);
      default:    chk($sformatf("%s:timeout_latency_%0d_in_range", v.name, lat),
                      64'(lat >= TIMEOUT + 1 && lat <= 2 * TIMEOUT + 3), 64'd1);
    endcase
    chk({v.name, ":status"}, 64'(status), 64'(v.exp_status));
    chk_wide({v.name, ":t_out"}, t_out, exp_t);
    chk({v.name, ":busy_until_done"}, 64'(gap), 64'd0);
    chk({v.name, ":busy_low_at_done"}, 64'(busy), 64'd0);
    chk({v.name, ":kdf_klen"}, 64'(kdf_klen), 64'(v.klen));
    chk({v.name, ":kdf_zin"}, 64'(kdf_zin == {X2, Y2}), 64'd1);
    repeat (3) begin
      @(negedge clk);
      if (busy || done || kdf_start) q = 1;
    end
    chk({v.name, ":quiet_after_done"}, 64'(q), 64'd0);
  endtask

  int  s;
  int  n;
  bit  saw;

  initial begin
    tab[0] = '{"t1_nominal",      32'd1000, 2, 70, -1, 2'd0, 1};
    tab[1] = '{"t2_klen0",        32'd0,    0,  0, -1, 2'd2, 0};
    tab[2] = '{"t2_klen1025",     32'd1025, 0,  0, -1, 2'd2, 0};
    tab[3] = '{"t3_zero_t",       32'd1000, 1, 12, -1, 2'd1, 1};
    tab[4] = '{"klen1024_bit0",   32'd1024, 1,  3, -1, 2'd0, 1};
    tab[5] = '{"klen1_msb",       32'd1,    0,  0, -1, 2'd0, 1};
    tab[6] = '{"lowest_kept_bit", 32'd1000, 3,  8, -1, 2'd0, 1};
    tab[7] = '{"first_cut_bit",   32'd1000, 4,  8,  5, 2'd1, 1};
    tab[8] = '{"t4_timeout",      32'd256,  0, -1, -1, 2'd3, 1};

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      run_op(tab[v]);
      if (v == 0) chk("t1:t_out_low24", 64'(t_out[23:0]), 64'd0);
      if (v == 5) chk("klen1:t_out_msb_only", 64'(t_out == {1'b1, {(KMAX-1){1'b0}}}), 64'd1);
    end

    // abort while in CHECK
    @(negedge clk);
    req = 1'b1; req_klen = 32'd512;
    @(negedge clk);
    req = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_check:busy", 64'(busy), 64'd0);
    saw = 0;
    repeat (6) begin
      if (done || kdf_start || busy) saw = 1;
      @(negedge clk);
    end
    chk("abort_check:quiet", 64'(saw), 64'd0);

    // abort 10 cycles into WAIT, late KDF strobe 20 cycles later
    @(negedge clk);
    req = 1'b1; req_klen = 32'd512;
    s = -1;
    for (int i = 0; i < 8 && s < 0; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (kdf_start) s = cyc;
    end
    chk("abort_wait:start_seen", 64'(s >= 0), 64'd1);
    saw = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done) saw = 1;
      if (cyc == s + 30) chk("abort_wait:busy_in_flush", 64'(busy), 64'd1);
      if (cyc == s + 31) chk("abort_wait:busy_drop", 64'(busy), 64'd0);
      abort = (cyc == s + 10);
      kdf_kout_valid = (cyc == s + 30);
      kdf_kout = '1;
    end
    abort = 1'b0;
    kdf_kout_valid = 1'b0;
    chk("abort_wait:no_done", 64'(saw), 64'd0);
    run_op(tab[0]);

    // reset dropped mid-WAIT
    @(negedge clk);
    req = 1'b1; req_x2 = X2; req_y2 = Y2; req_klen = 32'd1000;
    s = -1;
    for (int i = 0; i < 8 && s < 0; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (kdf_start) s = cyc;
    end
    chk("rst_mid:start_seen", 64'(s >= 0), 64'd1);
    repeat (5) @(negedge clk);
    chk("rst_mid:busy_before", 64'(busy), 64'd1);
    #2 rstn = 1'b0;
    #1 chk_reset("rst_mid_async");
    @(negedge clk);
    @(negedge clk);
    chk_reset("rst_mid_held");
    rstn = 1'b1;

    // KDF strobe while idle must not start anything
    @(negedge clk);
    kdf_kout_valid = 1'b1; kdf_kout = '1;
    @(negedge clk);
    kdf_kout_valid = 1'b0;
    saw = 0;
    repeat (4) begin
      if (busy || done) saw = 1;
      @(negedge clk);
    end
    chk("idle_valid:ignored", 64'(saw), 64'd0);
    run_op(tab[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
